// File: rtl/reg_bank.sv
// General-purpose register bank with per-write LOAD/INC/DEC/SHL, clear-all, two registered read ports and ovf/err pulses.
// Define REG_BANK_BYPASS_EN to forward same-cycle write results to the read ports.
module reg_bank #(
    parameter int WIDTH    = 4,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_all,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_op,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  qa,
    output logic [WIDTH-1:0]  qb,
    output logic              ovf,
    output logic              err
);

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_SHL  = 2'b11
    } op_e;

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];
    logic [WIDTH-1:0] qa_q, qa_d, qb_q, qb_d;
    logic             ovf_q, ovf_d, err_q, err_d;
    logic [WIDTH-1:0] oldVal;
    logic             wrInRange, rdAInRange, rdBInRange;

    assign wrInRange  = int'(wr_addr)   < NUM_REGS;
    assign rdAInRange = int'(rd_addr_a) < NUM_REGS;
    assign rdBInRange = int'(rd_addr_b) < NUM_REGS;

    // Register update: clear-all beats any write issued in the same cycle.
    always_comb begin
        regs_d = regs_q;
        ovf_d  = 1'b0;
        oldVal = '0;
        if (clr_all) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_d[i] = '0;
            end
        end else if (wr_en && wrInRange) begin
            oldVal = regs_q[wr_addr];
            case (op_e'(wr_op))
                OP_LOAD: regs_d[wr_addr] = wr_data;
                OP_INC: begin
                    regs_d[wr_addr] = oldVal + 1'b1;
                    ovf_d           = &oldVal;
                end
                OP_DEC: begin
                    regs_d[wr_addr] = oldVal - 1'b1;
                    ovf_d           = ~|oldVal;
                end
                OP_SHL: begin
                    regs_d[wr_addr] = {oldVal[WIDTH-2:0], 1'b0};
                    ovf_d           = oldVal[WIDTH-1];
                end
                default: regs_d[wr_addr] = oldVal;
            endcase
        end
    end

    // Forwarding reads from the next-state array also covers clear-all, since it zeroes regs_d.
    always_comb begin
        qa_d = '0;
        qb_d = '0;
`ifdef REG_BANK_BYPASS_EN
        if (rdAInRange) qa_d = regs_d[rd_addr_a];
        if (rdBInRange) qb_d = regs_d[rd_addr_b];
`else
        if (rdAInRange) qa_d = regs_q[rd_addr_a];
        if (rdBInRange) qb_d = regs_q[rd_addr_b];
`endif
        err_d = (wr_en && !clr_all && !wrInRange) || !rdAInRange || !rdBInRange;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            qa_q  <= '0;
            qb_q  <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            qa_q   <= qa_d;
            qb_q   <= qb_d;
            ovf_q  <= ovf_d;
            err_q  <= err_d;
        end
    end

    assign qa  = qa_q;
    assign qb  = qb_q;
    assign ovf = ovf_q;
    assign err = err_q;

endmodule
